matrix_mult: RTL and testbench
==============================

# matrix_mult

Streaming integer matrix-multiply engine. It computes OUT[M×O] = IN[M×N] · W[N×O]. IN is held in a row-addressed input memory: one row of N elements per address. W is held transposed in a weight memory: address o holds column o of W as N elements. For each input row, the block sweeps all O weight rows, forms N-wide dot products, and writes one packed output row per input row to an output memory. It sits between three synchronous-read RAMs with a one-cycle read latency and is launched by a start edge.

## Interface
Parameters:
- BATCH_SIZE, 8: M, the number of input/output rows.
- LOG_BATCH_SIZE, 3: log2(M), the width of the row addresses.
- INPUT_FEATURES, 4: N, the dot-product length.
- LOG_INPUT_FEATURES, 2: log2(N).
- OUTPUT_FEATURES, 8: O, the number of output columns (weight rows).
- LOG_OUTPUT_FEATURES, 3: log2(O).
- INPUT_WIDTH, 4: bits per input element.
- WEIGHT_WIDTH, 8: bits per weight element.
- OUTPUT_WIDTH, 16: bits per output element.

Ports:
- clk, in, 1: the single clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: launch request, acted on at its rising edge.
- inputData, in, N·INPUT_WIDTH: input-memory read data. Element k is at bits [k·INPUT_WIDTH +: INPUT_WIDTH].
- weightData, in, N·WEIGHT_WIDTH: weight-memory read data. Element k is at bits [k·WEIGHT_WIDTH +: WEIGHT_WIDTH].
- inputAddr, out, LOG_BATCH_SIZE: input-memory read address (m).
- weightAddr, out, LOG_OUTPUT_FEATURES: weight-memory read address (o).
- outputData, out, O·OUTPUT_WIDTH: output row. Column o is at bits [o·OUTPUT_WIDTH +: OUTPUT_WIDTH].
- outputAddr, out, LOG_BATCH_SIZE: output-memory write address.
- outputWrEn, out, 1: output-memory write strobe, one cycle per row.

## Operation
- States:
  - IDLE: addresses held at 0.
  - RUN: address sweep in progress.
  - DRAIN: the last data beat and the last write are completing.
- Transitions:
  - IDLE→RUN when start is sampled 1 and was sampled 0 on the previous edge (rising edge; start held high does not relaunch).
  - RUN→DRAIN after issuing address pair k = M·O−1.
  - DRAIN→IDLE after the final write.
- Sweep order in RUN:
  - k = 0…M·O−1, with m = k / O and o = k mod O.
  - inputAddr = m, weightAddr = o. The weight index is the inner loop and wraps to 0 as m increments.
- Arithmetic:
  - Elements are signed two's complement.
  - Each product is INPUT_WIDTH+WEIGHT_WIDTH bits. The N products are summed at full precision.
  - The sum is truncated (wrap) to OUTPUT_WIDTH and stored into row-register slot o.
- Output row register: O·OUTPUT_WIDTH bits, driven directly onto outputData. Slots are overwritten in place; no double buffer is needed (see Timing).
- start while in RUN or DRAIN is ignored.
- rst_n low, at any time including mid-run, immediately forces the following; no partial-row write occurs:
  - state to IDLE;
  - inputAddr, weightAddr, outputAddr and outputData to 0;
  - outputWrEn to 0.

## Timing
- Cycle 0 is the first cycle after the edge that detects the start edge. Address pair k is driven, registered, during cycle k.
- The memory returns data for pair k during cycle k+1. The dot product is computed combinationally and latched into slot o at the end of cycle k+1.
- When o = O−1, during cycle k+2:
  - outputWrEn = 1;
  - outputAddr = m;
  - outputData = the complete row m.
- Slot 0 of row m+1 is overwritten only at the end of cycle k+2, so the written row is never corrupted.
- Latencies:
  - First write occurs in cycle O+1.
  - Writes are exactly O cycles apart.
  - The last write (row M−1) occurs in cycle M·O+1.
  - Back in IDLE from cycle M·O+2, with outputWrEn = 0.
- A run produces exactly M writes; outputWrEn is never high for two consecutive cycles when O > 1.
- outputData holds its last value in IDLE until reset or the next run.

## Test plan
- Reset then idle: with rst_n low, all outputs are 0. After release with start = 0 for 20 cycles, there are no writes and the addresses stay 0.
- Identity check: IN rows = random 4-bit values; W = [I4 | I4] (columns 0–3 and 4–7 are e_0…e_3). Each output row m is then {IN[m], IN[m]} sign-extended to 16 bits, over 8 writes at outputAddr 0…7.
- Full random vs. model: random signed IN and W with behavioural sync-read RAMs. All 8 rows match the golden product. Writes land in cycles 9, 17, …, 65.
- Extremes: all IN = −8 and all W = −128 give every output = 4·1024 = 4096 (0x1000). Mixed IN = 7, W = −128 gives −3584 (0xF200).
- Held start: start held high for 200 cycles gives exactly 8 writes, then idle. Dropping start low then high launches a second run with 8 further writes.
- Mid-run reset: assert rst_n low in cycle 30, then release. There is no write in that cycle or during reset, all outputs are 0, and a new start edge gives a complete, correct 8-row run.

Source files
------------

// File: rtl/matrix_mult.sv
// Streaming integer matrix multiply: OUT[M x O] = IN[M x N] * W[N x O], W stored transposed.
// Sweeps (row, weight-row) address pairs into sync-read RAMs and writes one packed output row per input row.
module matrix_mult #(
    parameter int unsigned BATCH_SIZE          = 8,
    parameter int unsigned LOG_BATCH_SIZE      = 3,
    parameter int unsigned INPUT_FEATURES      = 4,
    parameter int unsigned LOG_INPUT_FEATURES  = 2,
    parameter int unsigned OUTPUT_FEATURES     = 8,
    parameter int unsigned LOG_OUTPUT_FEATURES = 3,
    parameter int unsigned INPUT_WIDTH         = 4,
    parameter int unsigned WEIGHT_WIDTH        = 8,
    parameter int unsigned OUTPUT_WIDTH        = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]     inputData,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0]    weightData,
    output logic [LOG_BATCH_SIZE-1:0]                 inputAddr,
    output logic [LOG_OUTPUT_FEATURES-1:0]            weightAddr,
    output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]   outputData,
    output logic [LOG_BATCH_SIZE-1:0]                 outputAddr,
    output logic                                      outputWrEn
);

    localparam int unsigned ACC_W = INPUT_WIDTH + WEIGHT_WIDTH + LOG_INPUT_FEATURES;
    localparam int unsigned SUM_W = (ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic                           startPrev;
    logic                           validD;
    logic [LOG_OUTPUT_FEATURES-1:0] oD;
    logic [LOG_BATCH_SIZE-1:0]      mD;
    logic                           lastO;
    logic                           lastPair;
    logic signed [SUM_W-1:0]        dotSum;

    assign lastO    = (weightAddr == LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1));
    assign lastPair = lastO && (inputAddr == LOG_BATCH_SIZE'(BATCH_SIZE - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; DRAIN ends once the last data beat has been consumed
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start && !startPrev) nextState = RUN;
            RUN:     if (lastPair) nextState = DRAIN;
            DRAIN:   if (!validD) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Address sweep: weight index is the inner loop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startPrev  <= 1'b0;
            inputAddr  <= '0;
            weightAddr <= '0;
        end else begin
            startPrev <= start;
            if (state == RUN) begin
                if (lastO) begin
                    weightAddr <= '0;
                    inputAddr  <= lastPair ? '0 : inputAddr + 1'b1;
                end else begin
                    weightAddr <= weightAddr + 1'b1;
                end
            end else begin
                inputAddr  <= '0;
                weightAddr <= '0;
            end
        end
    end

    // Signed N-wide dot product of the current RAM beat
    always_comb begin
        dotSum = '0;
        for (int k = 0; k < int'(INPUT_FEATURES); k++) begin
            dotSum = dotSum
                   + SUM_W'($signed(inputData[k*INPUT_WIDTH +: INPUT_WIDTH]))
                   * SUM_W'($signed(weightData[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    end

    // Data beat tracking, slot fill and row write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validD     <= 1'b0;
            oD         <= '0;
            mD         <= '0;
            outputData <= '0;
            outputAddr <= '0;
            outputWrEn <= 1'b0;
        end else begin
            validD <= (state == RUN);
            oD     <= weightAddr;
            mD     <= inputAddr;
            if (validD) begin
                outputData[oD*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= OUTPUT_WIDTH'(dotSum);
            end
            outputWrEn <= validD && (oD == LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1));
            if (validD && (oD == LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1))) begin
                outputAddr <= mD;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult.sv
// Directed bench for matrix_mult with behavioural sync-read input and weight memories.
module tb_matrix_mult;

    localparam int M  = 8;
    localparam int N  = 4;
    localparam int O  = 8;
    localparam int IW = 4;
    localparam int WW = 8;
    localparam int OW = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [N*IW-1:0]   inputData;
    logic [N*WW-1:0]   weightData;
    logic [2:0]        inputAddr;
    logic [2:0]        weightAddr;
    logic [O*OW-1:0]   outputData;
    logic [2:0]        outputAddr;
    logic              outputWrEn;

    matrix_mult dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .inputData  (inputData),
        .weightData (weightData),
        .inputAddr  (inputAddr),
        .weightAddr (weightAddr),
        .outputData (outputData),
        .outputAddr (outputAddr),
        .outputWrEn (outputWrEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N*IW-1:0] inMem [M];
    logic [N*WW-1:0] wMem  [O];
    int inEl [M][N];
    int wEl  [O][N];

    always @(posedge clk) begin
        inputData  <= inMem[inputAddr];
        weightData <= wMem[weightAddr];
    end

    int nChecks = 0;
    int nErrors = 0;

    int          nWr;
    int          backToBack;
    logic [2:0]  wrAddr [64];
    logic [O*OW-1:0] wrData [64];
    int          wrCyc  [64];
    logic [2:0]  tIn [256];
    logic [2:0]  tW  [256];
    logic        tEn [256];

    task automatic load_mems();
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++)
                inMem[m][k*IW +: IW] = IW'(inEl[m][k]);
        for (int o = 0; o < O; o++)
            for (int k = 0; k < N; k++)
                wMem[o][k*WW +: WW] = WW'(wEl[o][k]);
    endtask

    function automatic logic [O*OW-1:0] golden_row(input int m);
        logic [O*OW-1:0] r;
        int s;
        r = '0;
        for (int o = 0; o < O; o++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += inEl[m][k] * wEl[o][k];
            r[o*OW +: OW] = OW'(s);
        end
        return r;
    endfunction

    // Launch one run and record writes and the address trace, cycle 0 = first RUN cycle
    task automatic run_collect(input bit holdStart, input int budget);
        logic prevEn;
        nWr = 0;
        backToBack = 0;
        prevEn = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            tIn[c] = inputAddr;
            tW[c]  = weightAddr;
            tEn[c] = outputWrEn;
            if (outputWrEn && prevEn) backToBack++;
            prevEn = outputWrEn;
            if (outputWrEn) begin
                if (nWr < 64) begin
                    wrAddr[nWr] = outputAddr;
                    wrData[nWr] = outputData;
                    wrCyc[nWr]  = c;
                end
                nWr++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if (outputWrEn !== 1'b0) begin nErrors++; $display("FAIL reset_wren got %b want 0", outputWrEn); end
        nChecks++; if (inputAddr !== 3'd0) begin nErrors++; $display("FAIL reset_inaddr got %0d want 0", inputAddr); end
        nChecks++; if (weightAddr !== 3'd0) begin nErrors++; $display("FAIL reset_waddr got %0d want 0", weightAddr); end
        nChecks++; if (outputAddr !== 3'd0) begin nErrors++; $display("FAIL reset_outaddr got %0d want 0", outputAddr); end
        nChecks++; if (outputData !== '0) begin nErrors++; $display("FAIL reset_outdata got %h want 0", outputData); end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            nChecks++;
            if (outputWrEn !== 1'b0 || inputAddr !== 3'd0 || weightAddr !== 3'd0) begin
                nErrors++;
                $display("FAIL idle_quiet cycle %0d got wren=%b in=%0d w=%0d want 0/0/0", c, outputWrEn, inputAddr, weightAddr);
            end
        end
    endtask

    task automatic test_identity();
        logic [O*OW-1:0] exp;
        logic [IW-1:0] v;
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++) inEl[m][k] = int'($urandom_range(15)) - 8;
        for (int o = 0; o < O; o++)
            for (int k = 0; k < N; k++) wEl[o][k] = (k == o % 4) ? 1 : 0;
        load_mems();
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL ident_count got %0d want 8", nWr); end
        for (int i = 0; i < 8 && i < nWr; i++) begin
            exp = '0;
            for (int o = 0; o < O; o++) begin
                v = IW'(inEl[i][o % 4]);
                exp[o*OW +: OW] = {{(OW-IW){v[IW-1]}}, v};
            end
            nChecks++; if (wrAddr[i] !== 3'(i)) begin nErrors++; $display("FAIL ident_addr %0d got %0d want %0d", i, wrAddr[i], i); end
            nChecks++; if (wrData[i] !== exp) begin nErrors++; $display("FAIL ident_row %0d got %h want %h", i, wrData[i], exp); end
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++) inEl[m][k] = int'($urandom_range(15)) - 8;
        for (int o = 0; o < O; o++)
            for (int k = 0; k < N; k++) wEl[o][k] = int'($urandom_range(255)) - 128;
        load_mems();
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL rand_count got %0d want 8", nWr); end
        nChecks++; if (backToBack !== 0) begin nErrors++; $display("FAIL rand_b2b got %0d want 0", backToBack); end
        for (int i = 0; i < 8 && i < nWr; i++) begin
            nChecks++; if (wrAddr[i] !== 3'(i)) begin nErrors++; $display("FAIL rand_addr %0d got %0d want %0d", i, wrAddr[i], i); end
            nChecks++; if (wrCyc[i] !== 9 + 8*i) begin nErrors++; $display("FAIL rand_cycle %0d got %0d want %0d", i, wrCyc[i], 9 + 8*i); end
            nChecks++; if (wrData[i] !== golden_row(i)) begin nErrors++; $display("FAIL rand_row %0d got %h want %h", i, wrData[i], golden_row(i)); end
        end
        for (int c = 0; c < 64; c++) begin
            nChecks++;
            if (tIn[c] !== 3'(c / 8) || tW[c] !== 3'(c % 8)) begin
                nErrors++;
                $display("FAIL rand_sweep cycle %0d got %0d/%0d want %0d/%0d", c, tIn[c], tW[c], c / 8, c % 8);
            end
        end
        for (int c = 66; c < 80; c++) begin
            nChecks++;
            if (tEn[c] !== 1'b0 || tIn[c] !== 3'd0 || tW[c] !== 3'd0) begin
                nErrors++;
                $display("FAIL rand_idle cycle %0d got wren=%b in=%0d w=%0d want 0/0/0", c, tEn[c], tIn[c], tW[c]);
            end
        end
        nChecks++; if (outputData !== golden_row(7)) begin nErrors++; $display("FAIL rand_hold got %h want %h", outputData, golden_row(7)); end
    endtask

    task automatic test_extremes();
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) inEl[m][k] = -8;
        for (int o = 0; o < O; o++) for (int k = 0; k < N; k++) wEl[o][k] = -128;
        load_mems();
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL ext_neg_count got %0d want 8", nWr); end
        for (int i = 0; i < 8 && i < nWr; i++) begin
            nChecks++; if (wrData[i] !== {8{16'h1000}}) begin nErrors++; $display("FAIL ext_neg_row %0d got %h want all 1000", i, wrData[i]); end
        end
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) inEl[m][k] = 7;
        load_mems();
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL ext_mix_count got %0d want 8", nWr); end
        for (int i = 0; i < 8 && i < nWr; i++) begin
            nChecks++; if (wrData[i] !== {8{16'hF200}}) begin nErrors++; $display("FAIL ext_mix_row %0d got %h want all f200", i, wrData[i]); end
        end
    endtask

    task automatic test_held_start();
        run_collect(1'b1, 200);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL held_count got %0d want 8", nWr); end
        nChecks++; if (wrCyc[7] !== 65) begin nErrors++; $display("FAIL held_last_cycle got %0d want 65", wrCyc[7]); end
        repeat (2) @(negedge clk);
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL relaunch_count got %0d want 8", nWr); end
    endtask

    task automatic test_midrun_reset();
        int early;
        early = 0;
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++) inEl[m][k] = int'($urandom_range(15)) - 8;
        for (int o = 0; o < O; o++)
            for (int k = 0; k < N; k++) wEl[o][k] = int'($urandom_range(255)) - 128;
        load_mems();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (outputWrEn) early++;
        end
        nChecks++; if (early !== 3) begin nErrors++; $display("FAIL mid_early_writes got %0d want 3", early); end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (outputWrEn !== 1'b0 || inputAddr !== 3'd0 || weightAddr !== 3'd0 || outputAddr !== 3'd0 || outputData !== '0) begin
            nErrors++;
            $display("FAIL mid_reset_outputs got wren=%b in=%0d w=%0d oa=%0d od=%h want all 0", outputWrEn, inputAddr, weightAddr, outputAddr, outputData);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nChecks++; if (outputWrEn !== 1'b0) begin nErrors++; $display("FAIL mid_reset_wren cycle %0d got %b want 0", c, outputWrEn); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++; if (outputWrEn !== 1'b0 || inputAddr !== 3'd0) begin nErrors++; $display("FAIL mid_post_idle got wren=%b in=%0d want 0/0", outputWrEn, inputAddr); end
        run_collect(1'b0, 80);
        nChecks++; if (nWr !== 8) begin nErrors++; $display("FAIL mid_rerun_count got %0d want 8", nWr); end
        for (int i = 0; i < 8 && i < nWr; i++) begin
            nChecks++;
            if (wrAddr[i] !== 3'(i) || wrData[i] !== golden_row(i)) begin
                nErrors++;
                $display("FAIL mid_rerun_row %0d got addr %0d data %h want addr %0d data %h", i, wrAddr[i], wrData[i], i, golden_row(i));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int m = 0; m < M; m++) inMem[m] = '0;
        for (int o = 0; o < O; o++) wMem[o] = '0;
        test_reset();
        test_identity();
        test_random();
        test_extremes();
        test_held_start();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
